// File: rtl/qcm_pkg.sv
// Shared definitions for the capacitor-bank tuning sequencer.
package qcm_pkg;
  localparam int STATE_W = 7;
  localparam int MAX_STATE = 80;
  localparam logic [STATE_W-1:0] BASELOAD_STATE = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUALIFY,
    S_BREAK,
    S_LOAD,
    S_HOLD
  } seq_state_e;
endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the settle, break and hold phases.
// done is high on the last counted cycle (count of 1), so a load of N
// gives N clock edges including the one that observes done.
module seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);
  logic [CNT_W-1:0] count;

  assign done = (count <= CNT_W'(1));

  // load takes priority over decrement; counter saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= '0;
    else if (load)                     count <= load_val;
    else if (dec && (count != '0))     count <= count - CNT_W'(1);
  end
endmodule

// File: rtl/lut_state_sequencer.sv
// Qualifies LUT tuning requests and applies them break-before-make:
// drivers off, new state loaded, drivers on, then a minimum dwell.
module lut_state_sequencer #(
  parameter int STATE_W       = qcm_pkg::STATE_W,
  parameter int MAX_STATE     = qcm_pkg::MAX_STATE,
  parameter int SETTLE_CYCLES = 4,
  parameter int BREAK_CYCLES  = 16,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [STATE_W-1:0] lut_state,
  input  logic               clr_err,
  output logic [STATE_W-1:0] applied_state,
  output logic               drv_en,
  output logic               state_strobe,
  output logic               busy,
  output logic               range_err
);
  import qcm_pkg::*;

  localparam logic [STATE_W-1:0] MAX_CODE  = STATE_W'(MAX_STATE);
  localparam logic [STATE_W-1:0] BASE_CODE = STATE_W'(BASELOAD_STATE);
  // The first matching sample is taken in IDLE, so the timer covers the rest.
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BREAK_LD  = CNT_W'(BREAK_CYCLES);
  localparam logic [CNT_W-1:0]   HOLD_LD   = CNT_W'(HOLD_CYCLES);

  seq_state_e         st, nxt;
  logic [STATE_W-1:0] cand, nxt_cand, nxt_app;
  logic               nxt_drv, nxt_strobe, nxt_err, lut_bad;
  logic               t_load, t_dec, t_done;
  logic [CNT_W-1:0]   t_val;

  assign lut_bad = (lut_state > MAX_CODE);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .done     (t_done)
  );

  // Next-state and next-output decode
  always_comb begin
    nxt        = st;
    nxt_cand   = cand;
    nxt_app    = applied_state;
    nxt_drv    = drv_en;
    nxt_strobe = 1'b0;
    t_load     = 1'b0;
    t_val      = '0;
    t_dec      = 1'b0;
    // a set in the same cycle as a clear wins
    nxt_err    = (enable && lut_bad) || (range_err && !clr_err);
    case (st)
      S_IDLE: begin
        nxt_drv = enable;
        if (enable && !lut_bad && (lut_state != applied_state)) begin
          nxt_cand = lut_state;
          t_load   = 1'b1;
          t_val    = SETTLE_LD;
          nxt      = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        if (!enable) begin
          nxt = S_IDLE;
        end else if (lut_state != cand) begin
          // back to the applied value, or garbage: drop the request quietly
          if ((lut_state == applied_state) || lut_bad) begin
            nxt = S_IDLE;
          end else begin
            nxt_cand = lut_state;
            t_load   = 1'b1;
            t_val    = SETTLE_LD;
          end
        end else if (t_done) begin
          nxt_drv = 1'b0;
          t_load  = 1'b1;
          t_val   = BREAK_LD;
          nxt     = S_BREAK;
        end else begin
          t_dec = 1'b1;
        end
      end
      S_BREAK: begin
        nxt_drv = 1'b0;
        if (!enable) begin
          nxt = S_IDLE;
        end else if (t_done) begin
          nxt_app    = cand;
          nxt_strobe = 1'b1;
          nxt        = S_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      S_LOAD: begin
        if (!enable) begin
          nxt_drv = 1'b0;
          nxt     = S_IDLE;
        end else begin
          nxt_drv = 1'b1;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
          nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        // lut_state deliberately ignored for the dwell
        if (!enable) begin
          nxt_drv = 1'b0;
          nxt     = S_IDLE;
        end else begin
          nxt_drv = 1'b1;
          if (t_done) nxt = S_IDLE;
          else        t_dec = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= S_IDLE;
      cand          <= BASE_CODE;
      applied_state <= BASE_CODE;
      drv_en        <= 1'b0;
      state_strobe  <= 1'b0;
      busy          <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      st            <= nxt;
      cand          <= nxt_cand;
      applied_state <= nxt_app;
      drv_en        <= nxt_drv;
      state_strobe  <= nxt_strobe;
      busy          <= (nxt != S_IDLE);
      range_err     <= nxt_err;
    end
  end
endmodule

// File: tb/tb_lut_state_sequencer.sv
// Randomized bench for lut_state_sequencer against a timeline model of a
// tuning request, plus literal expectations from the documented timings.
module tb_lut_state_sequencer;
  localparam int SETTLE = 4;
  localparam int BRK    = 16;
  localparam int HLD    = 16;
  localparam int MAXS   = 80;
  // Offsets from the edge that first sampled a new request.
  localparam int T_OFF  = SETTLE - 1;      // drivers go off
  localparam int T_LOAD = T_OFF + BRK;     // new state presented
  localparam int T_ON   = T_LOAD + 1;      // drivers back on
  localparam int T_DONE = T_ON + HLD;      // dwell over

  localparam int SG_APP = 0, SG_DRV = 1, SG_STB = 2, SG_BUSY = 3, SG_ERR = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic [6:0] lut_state = 7'd0;
  logic [6:0] applied_state;
  logic       drv_en, state_strobe, busy, range_err;

  lut_state_sequencer #(
    .STATE_W(7), .MAX_STATE(MAXS), .SETTLE_CYCLES(SETTLE),
    .BREAK_CYCLES(BRK), .HOLD_CYCLES(HLD), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .enable        (enable),
    .lut_state     (lut_state),
    .clr_err       (clr_err),
    .applied_state (applied_state),
    .drv_en        (drv_en),
    .state_strobe  (state_strobe),
    .busy          (busy),
    .range_err     (range_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int cyc = 0;
  bit m_busy = 0, m_drv = 0, m_strobe = 0, m_err = 0;
  int m_start = 0, m_cand = 0, m_app = 0;
  int age;
  bit bad;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_start = 0; m_cand = 0; m_app = 0;
      m_drv = 0; m_strobe = 0; m_err = 0;
    end else begin
      cyc++;
      bad = (int'(lut_state) > MAXS);
      if (enable && bad) m_err = 1;
      else if (clr_err)  m_err = 0;
      m_strobe = 0;
      if (!m_busy) begin
        m_drv = enable;
        if (enable && !bad && int'(lut_state) != m_app) begin
          m_busy = 1; m_start = cyc; m_cand = int'(lut_state);
        end
      end else begin
        age = cyc - m_start;
        if (age <= T_OFF) begin
          if (!enable) m_busy = 0;
          else if (int'(lut_state) != m_cand) begin
            if (int'(lut_state) == m_app || bad) m_busy = 0;
            else begin m_start = cyc; m_cand = int'(lut_state); end
          end else if (age == T_OFF) m_drv = 0;
        end else begin
          if (!enable)              begin m_busy = 0; m_drv = 0; end
          else if (age == T_LOAD)   begin m_app = m_cand; m_strobe = 1; end
          else if (age == T_ON)     m_drv = 1;
          else if (age == T_DONE)   m_busy = 0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct { int c; int sig; int val; string nm; } lit_t;
  lit_t lq[$];
  int n_chk = 0, n_fail = 0;

  function automatic void expect_at(int c, int sig, int val, string nm);
    lit_t e;
    e.c = c; e.sig = sig; e.val = val; e.nm = nm;
    lq.push_back(e);
  endfunction

  function automatic int dut_sig(int sig);
    case (sig)
      SG_APP:  return int'(applied_state);
      SG_DRV:  return int'(drv_en);
      SG_STB:  return int'(state_strobe);
      SG_BUSY: return int'(busy);
      default: return int'(range_err);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("applied_state", int'(applied_state), m_app);
    chk("drv_en",        int'(drv_en),        int'(m_drv));
    chk("state_strobe",  int'(state_strobe),  int'(m_strobe));
    chk("busy",          int'(busy),          int'(m_busy));
    chk("range_err",     int'(range_err),     int'(m_err));
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].c == cyc) begin
        chk(lq[i].nm, dut_sig(lq[i].sig), lq[i].val);
        lq.delete(i);
      end
    end
  end

  // ---------------- stimulus ----------------
  int k, k2, len, r, r2, v;
  int picks[4] = '{0, 37, 38, 80};

  initial begin
    rst = 1'b1; enable = 1'b0; lut_state = 7'd37;
    expect_at(0, SG_APP, 0, "rst_applied");
    expect_at(0, SG_DRV, 0, "rst_drv");
    expect_at(0, SG_BUSY, 0, "rst_busy");
    repeat (3) @(negedge clk);

    // release reset, drivers follow enable at the next edge
    rst = 1'b0; enable = 1'b1; lut_state = 7'd0;
    k = cyc + 1;
    expect_at(k, SG_DRV, 1, "en_drv_on");
    expect_at(k, SG_STB, 0, "en_no_strobe");
    repeat (4) @(negedge clk);

    // chattering request never qualifies
    for (int i = 0; i < 12; i++) begin
      lut_state = (i % 2 == 1) ? 7'd38 : 7'd37;
      if (i == 11) begin
        expect_at(cyc + 1, SG_DRV, 1, "toggle_drv");
        expect_at(cyc + 1, SG_APP, 0, "toggle_app");
      end
      repeat (2) @(negedge clk);
    end
    lut_state = 7'd0;
    repeat (3) @(negedge clk);

    // clean step 0 -> 37
    lut_state = 7'd37;
    k = cyc + 1;
    expect_at(k + 2,  SG_DRV, 1,  "step_drv_pre");
    expect_at(k + 3,  SG_DRV, 0,  "step_drv_off");
    expect_at(k + 18, SG_APP, 0,  "step_app_pre");
    expect_at(k + 19, SG_APP, 37, "step_app");
    expect_at(k + 19, SG_STB, 1,  "step_strobe");
    expect_at(k + 20, SG_STB, 0,  "step_strobe_end");
    expect_at(k + 20, SG_DRV, 1,  "step_drv_on");
    expect_at(k + 35, SG_BUSY, 1, "step_busy_pre");
    expect_at(k + 36, SG_BUSY, 0, "step_busy_end");
    repeat (24) @(negedge clk);

    // request during the dwell is deferred until IDLE
    lut_state = 7'd50;
    k2 = k + 37;
    expect_at(k + 36, SG_APP, 37,  "hold_ignored");
    expect_at(k2,      SG_BUSY, 1, "hold_restart");
    expect_at(k2 + 18, SG_APP, 37, "defer_app_pre");
    expect_at(k2 + 19, SG_APP, 50, "defer_app");
    expect_at(k2 + 19, SG_STB, 1,  "defer_strobe");
    repeat (k2 + 40 - cyc) @(negedge clk);

    // range error: set, set-wins-over-clear, clear
    lut_state = 7'd100;
    expect_at(cyc + 1, SG_ERR, 1, "err_set");
    expect_at(cyc + 1, SG_APP, 50, "err_no_change");
    @(negedge clk);
    clr_err = 1'b1;
    expect_at(cyc + 1, SG_ERR, 1, "err_set_wins");
    @(negedge clk);
    lut_state = 7'd50;
    expect_at(cyc + 1, SG_ERR, 0, "err_clear");
    @(negedge clk);
    clr_err = 1'b0;
    repeat (2) @(negedge clk);

    // abort in the break window keeps the old state
    lut_state = 7'd37;
    k = cyc + 1;
    expect_at(k + 9,  SG_DRV, 0,  "abort_drv_off");
    expect_at(k + 10, SG_DRV, 0,  "abort_drv");
    expect_at(k + 10, SG_BUSY, 0, "abort_busy");
    expect_at(k + 10, SG_APP, 50, "abort_app");
    repeat (9) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    lut_state = 7'd50;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // randomized traffic
    for (int s = 0; s < 200; s++) begin
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      enable = (r >= 6);
      if (r2 < 10)      lut_state = 7'($urandom_range(81, 127));
      else if (r2 < 40) lut_state = 7'(picks[$urandom_range(0, 3)]);
      else if (r2 < 55) lut_state = 7'(m_app);
      else              lut_state = 7'($urandom_range(0, 80));
      len = (r < 6) ? $urandom_range(1, 4) : $urandom_range(1, 45);
      for (int j = 0; j < len; j++) begin
        clr_err = ($urandom_range(0, 9) == 0);
        @(negedge clk);
      end
    end
    clr_err = 1'b0;

    // async reset in the middle of the dwell
    enable = 1'b0;
    repeat (2) @(negedge clk);
    lut_state = 7'(m_app);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    v = (m_app == 20) ? 21 : 20;
    lut_state = 7'(v);
    k = cyc + 1;
    expect_at(k + 20, SG_DRV, 1, "pre_rst_drv");
    expect_at(k + 24, SG_APP, v, "pre_rst_app");
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_at(cyc, SG_APP, 0,  "async_rst_app");
    expect_at(cyc, SG_DRV, 0,  "async_rst_drv");
    expect_at(cyc, SG_BUSY, 0, "async_rst_busy");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
